// File: rtl/sd_resp_rx.sv
// SD CMD-line response receiver: captures a 48- or 136-bit response frame and checks
// framing, CRC7 and the N_CR start-bit timeout.
module sd_resp_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TO_W           = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         long_resp,
  input  logic         check_crc,
  input  logic         sd_cmd_in,
  output logic         busy,
  output logic         resp_valid,
  output logic [135:0] resp,
  output logic         crc_err,
  output logic         frame_err,
  output logic         timeout
);

  typedef enum logic [1:0] {IDLE, WAIT_START, RECV, DONE} state_t;

  state_t            r_state, w_next;
  logic              r_long, r_chk;
  logic [7:0]        r_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [6:0]        r_crc;
  logic [135:0]      r_resp;
  logic              r_crc_err, r_frame_err, r_timeout;

  logic [135:0]      w_shift;
  logic [7:0]        w_last_pos, w_crc_lo, w_crc_hi;
  logic              w_crc_en, w_end, w_fb, w_tx_bit, w_to_hit;
  logic [6:0]        w_crc_step;

  assign w_shift    = {r_resp[134:0], sd_cmd_in};
  assign w_last_pos = r_long ? 8'd135 : 8'd47;
  // r_cnt is the position of the incoming bit (0 = start bit); CRC spans positions lo..N-9
  assign w_crc_lo   = r_long ? 8'd8 : 8'd0;
  assign w_crc_hi   = r_long ? 8'd127 : 8'd39;
  assign w_crc_en   = (r_cnt >= w_crc_lo) && (r_cnt <= w_crc_hi);
  assign w_end      = (r_cnt == w_last_pos);
  assign w_fb       = sd_cmd_in ^ r_crc[6];
  assign w_crc_step = {r_crc[5:3], r_crc[2] ^ w_fb, r_crc[1:0], w_fb};
  assign w_tx_bit   = r_long ? r_resp[133] : r_resp[45];
  assign w_to_hit   = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       if (start) w_next = WAIT_START;
      WAIT_START: begin
        if (!sd_cmd_in)    w_next = RECV;
        else if (w_to_hit) w_next = DONE;
      end
      RECV:       if (w_end) w_next = DONE;
      DONE:       w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_long      <= 1'b0;
      r_chk       <= 1'b0;
      r_cnt       <= '0;
      r_to_cnt    <= '0;
      r_crc       <= '0;
      r_resp      <= '0;
      r_crc_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_long      <= long_resp;
            r_chk       <= check_crc;
            r_cnt       <= '0;
            r_to_cnt    <= '0;
            r_crc       <= '0;
            r_resp      <= '0;
            r_crc_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_timeout   <= 1'b0;
          end
        end
        WAIT_START: begin
          if (!sd_cmd_in) begin
            // a zero start bit leaves a zero CRC unchanged, so no CRC update here
            r_resp <= w_shift;
            r_cnt  <= 8'd1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
            if (w_to_hit) r_timeout <= 1'b1;
          end
        end
        RECV: begin
          r_resp <= w_shift;
          r_cnt  <= r_cnt + 8'd1;
          if (w_crc_en) r_crc <= w_crc_step;
          if (w_end) begin
            r_frame_err <= w_tx_bit | ~sd_cmd_in;
            r_crc_err   <= r_chk & (r_crc != r_resp[6:0]);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state != IDLE);
  assign resp_valid = (r_state == DONE);
  assign resp       = r_resp;
  assign crc_err    = r_crc_err;
  assign frame_err  = r_frame_err;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_sd_resp_rx.sv
// Directed bench for sd_resp_rx: frames are driven MSB-first and checked against a
// scoreboard of expected results built from an independent CRC7 long-division model.
module tb_sd_resp_rx;

  logic         clk = 1'b0;
  logic         reset, start, long_resp, check_crc, sd_cmd_in;
  logic         busy, resp_valid, crc_err, frame_err, timeout;
  logic [135:0] resp;

  sd_resp_rx #(.TIMEOUT_CYCLES(64), .TO_W(7)) dut (
    .clk(clk), .reset(reset), .start(start), .long_resp(long_resp),
    .check_crc(check_crc), .sd_cmd_in(sd_cmd_in), .busy(busy),
    .resp_valid(resp_valid), .resp(resp), .crc_err(crc_err),
    .frame_err(frame_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [135:0] resp;
    logic         crc;
    logic         fr;
    logic         to;
    int           t0;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] crc7_model(input logic [127:0] d, input int n);
    logic [134:0] v;
    v = 135'(d) << 7;
    for (int i = n + 6; i >= 7; i--)
      if (v[i]) v = v ^ (135'(8'h89) << (i - 7));
    return v[6:0];
  endfunction

  function automatic logic [135:0] mk_short(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] m;
    m = {2'b00, idx, arg};
    return {88'b0, m, crc7_model(128'(m), 40), 1'b1};
  endfunction

  task automatic arm(input logic l, input logic c);
    @(negedge clk);
    start = 1'b1; long_resp = l; check_crc = c;
    @(negedge clk);
    start = 1'b0; long_resp = 1'b0; check_crc = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      sd_cmd_in = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [135:0] f, input int n, input logic ecrc,
                            input logic efr, input int pulse_at);
    exp_t e;
    e.resp = f; e.crc = ecrc; e.fr = efr; e.to = 1'b0; e.t0 = cyc; e.lat = n;
    sb.push_back(e);
    for (int i = n - 1; i >= 0; i--) begin
      sd_cmd_in = f[i];
      start     = (i == pulse_at);
      @(negedge clk);
    end
    start     = 1'b0;
    sd_cmd_in = 1'b1;
  endtask

  task automatic check_resp(input string tag, input logic pulse_done);
    exp_t e;
    int   w = 0;
    while (!resp_valid && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "-valid"}, 136'(resp_valid), 136'(1));
    if (!resp_valid || sb.size() == 0) begin
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    chk({tag, "-resp"},    resp,              e.resp);
    chk({tag, "-crc"},     136'(crc_err),     136'(e.crc));
    chk({tag, "-frame"},   136'(frame_err),   136'(e.fr));
    chk({tag, "-timeout"}, 136'(timeout),     136'(e.to));
    chk({tag, "-latency"}, 136'(cyc - e.t0),  136'(e.lat));
    chk({tag, "-busy"},    136'(busy),        136'(1));
    if (pulse_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "-busy_after"},  136'(busy),       136'(0));
    chk({tag, "-valid_after"}, 136'(resp_valid), 136'(0));
    if (pulse_done) begin
      @(negedge clk);
      chk({tag, "-ignored_start"}, 136'(busy), 136'(0));
      chk({tag, "-hold_resp"},     resp,       e.resp);
      chk({tag, "-hold_crc"},      136'(crc_err), 136'(e.crc));
    end
  endtask

  initial begin
    logic [135:0] r1, r1_bad, lf;
    logic [127:0] rnd;
    logic [119:0] cid;
    exp_t         e;
    int           seen;

    reset = 1'b1; start = 1'b0; long_resp = 1'b0; check_crc = 1'b0; sd_cmd_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst-busy",  136'(busy),       136'(0));
    chk("rst-valid", 136'(resp_valid), 136'(0));
    chk("rst-resp",  resp,             136'(0));
    chk("rst-flags", 136'({crc_err, frame_err, timeout}), 136'(0));

    // Short frame, transmission bit set (CMD0 pattern with valid CRC)
    arm(1'b0, 1'b1);
    idle(5);
    send_frame(136'(48'h400000000095), 48, 1'b0, 1'b1, -1);
    check_resp("short-txbit", 1'b0);

    // R3, CRC check disabled
    arm(1'b0, 1'b0);
    idle(2);
    send_frame(136'(48'h3F00FF8000FF), 48, 1'b0, 1'b0, -1);
    check_resp("r3", 1'b0);

    // CMD55 R1 with good CRC; a start pulse mid-frame must be ignored
    r1 = mk_short(6'h37, 32'h0000_0120);
    arm(1'b0, 1'b1);
    idle(3);
    send_frame(r1, 48, 1'b0, 1'b0, 30);
    check_resp("r1-good", 1'b0);

    // Argument bit 20 flipped; start pulsed in the DONE cycle
    r1_bad = r1 ^ (136'(1) << 28);
    arm(1'b0, 1'b1);
    idle(1);
    send_frame(r1_bad, 48, 1'b1, 1'b0, -1);
    check_resp("r1-bad", 1'b1);

    // Long R2 frame
    rnd = {$urandom, $urandom, $urandom, $urandom};
    cid = rnd[119:0];
    lf  = {8'h3F, cid, crc7_model(128'(cid), 120), 1'b1};
    arm(1'b1, 1'b1);
    idle(4);
    send_frame(lf, 136, 1'b0, 1'b0, -1);
    check_resp("r2", 1'b0);

    // Timeout: CMD held high
    arm(1'b0, 1'b1);
    e.resp = '0; e.crc = 1'b0; e.fr = 1'b0; e.to = 1'b1; e.t0 = cyc; e.lat = 64;
    sb.push_back(e);
    sd_cmd_in = 1'b1;
    check_resp("timeout", 1'b0);

    // Start bit on the 64th clock wins over the timeout
    arm(1'b0, 1'b1);
    idle(63);
    send_frame(r1, 48, 1'b0, 1'b0, -1);
    check_resp("to-edge", 1'b0);

    // Reset 20 bits into a frame
    arm(1'b0, 1'b1);
    for (int i = 47; i >= 28; i--) begin
      sd_cmd_in = r1[i];
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sd_cmd_in = 1'b1;
    chk("midrst-busy",  136'(busy), 136'(0));
    chk("midrst-resp",  resp,       136'(0));
    chk("midrst-flags", 136'({crc_err, frame_err, timeout}), 136'(0));
    seen = 0;
    repeat (80) begin
      if (resp_valid || busy) seen++;
      @(negedge clk);
    end
    chk("midrst-quiet", 136'(seen), 136'(0));

    // Re-arm after reset
    arm(1'b0, 1'b1);
    idle(1);
    send_frame(r1_bad, 48, 1'b1, 1'b0, -1);
    check_resp("rearm", 1'b0);

    chk("sb-empty", 136'(sb.size()), 136'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
